// File: rtl/quad_ctrl_pkg.sv
// Shared types and constants for the four-digit BCD counter controller.
package quad_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// Single decimal digit: synchronous clear, increments on enable, wraps 9 -> 0.
module bcd_digit
  import quad_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] q_o
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (en_i) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/quad_count_ctrl.sv
// Run/pause/clear controller for a four-digit BCD counter with tick prescaler.
// Optional display freeze (lap) is built when QUAD_CTRL_LAP_EN is defined.
module quad_count_ctrl
  import quad_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter bit          WRAP     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        lap_i,
  output logic [15:0] digits_o,
  output logic [15:0] disp_o,
  output logic        running_o,
  output logic        done_o,
  output logic        tc_o
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [PrescW-1:0]  presc_q, presc_d;
  logic               tc_q;
  logic               tick;
  logic               at_max;
  logic               advance;
  logic               carry;
  logic [NUM_DIGITS-1:0] dig_en;
  logic [NUM_DIGITS-1:0] dig_nine;
  logic [3:0]         dig_q [NUM_DIGITS];

  assign running_o = (state_q == StRun);
  assign done_o    = (state_q == StDone);
  assign tc_o      = tc_q;
  assign tick      = running_o && (presc_q == PrescMax);

  // Ripple enable chain; with WRAP=0 the terminal tick is suppressed so 9999 holds.
  always_comb begin
    digits_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_nine[i]        = (dig_q[i] == BCD_MAX);
      digits_o[4*i +: 4] = dig_q[i];
    end
    at_max  = &dig_nine;
    advance = tick && (WRAP || !at_max) && !clear_i;
    carry   = advance;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_en[i] = carry;
      carry     = carry && dig_nine[i];
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (dig_en[i]),
      .q_o   (dig_q[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else if (tick && at_max && !WRAP) begin
      state_d = StDone;
    end else if (stop_i) begin
      if (state_q == StRun) state_d = StPause;
    end else if (start_i) begin
      if (state_q == StIdle || state_q == StPause) state_d = StRun;
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (clear_i) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else if (running_o) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      presc_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tc_q    <= tick && at_max && !clear_i;
    end
  end

`ifdef QUAD_CTRL_LAP_EN
  logic        freeze_q, freeze_d;
  logic [15:0] snap_q, snap_d;

  always_comb begin
    freeze_d = freeze_q;
    snap_d   = snap_q;
    if (clear_i) begin
      freeze_d = 1'b0;
    end else if (lap_i && (state_q == StRun || state_q == StPause)) begin
      freeze_d = !freeze_q;
    end
    if (freeze_d && !freeze_q) snap_d = digits_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      freeze_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      freeze_q <= freeze_d;
      snap_q   <= snap_d;
    end
  end

  assign disp_o = freeze_q ? snap_q : digits_o;
`else
  logic unused_lap;
  assign unused_lap = lap_i;
  assign disp_o     = digits_o;
`endif

endmodule

// File: tb/tb_quad_count_ctrl.sv
// Directed bench: three controller instances (wrap, hold, slow prescaler) checked via a scoreboard.
module tb_quad_count_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  start, stop, clear, lap;
  logic [15:0] digits [3];
  logic [15:0] disp [3];
  logic [2:0]  running, done, tc;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   ntot  = 0;

  // 0: TICK_DIV=1 WRAP=1, 1: TICK_DIV=1 WRAP=0, 2: TICK_DIV=4 WRAP=1
  quad_count_ctrl #(.TICK_DIV(1), .WRAP(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .stop_i(stop[0]), .clear_i(clear[0]),
    .lap_i(lap[0]), .digits_o(digits[0]), .disp_o(disp[0]), .running_o(running[0]),
    .done_o(done[0]), .tc_o(tc[0])
  );

  quad_count_ctrl #(.TICK_DIV(1), .WRAP(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .stop_i(stop[1]), .clear_i(clear[1]),
    .lap_i(lap[1]), .digits_o(digits[1]), .disp_o(disp[1]), .running_o(running[1]),
    .done_o(done[1]), .tc_o(tc[1])
  );

  quad_count_ctrl #(.TICK_DIV(4), .WRAP(1'b1)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .stop_i(stop[2]), .clear_i(clear[2]),
    .lap_i(lap[2]), .digits_o(digits[2]), .disp_o(disp[2]), .running_o(running[2]),
    .done_o(done[2]), .tc_o(tc[2])
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [15:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_next(input logic [15:0] got);
    exp_t e;
    ntot++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty: got %h expected queued_entry", got);
    end else begin
      e = sb.pop_front();
      assert (got === e.val) npass++;
      else $error("FAIL %s: got %h expected %h", e.tag, got, e.val);
    end
  endtask

  initial begin
    clk   = 1'b0;
    rst   = 1'b1;
    start = 3'b111;
    stop  = '0;
    clear = '0;
    lap   = '0;

    // Reset held two cycles with start asserted
    expect_val("rst.digits", 16'h0000);
    expect_val("rst.disp", 16'h0000);
    expect_val("rst.running", 16'd0);
    expect_val("rst.done", 16'd0);
    expect_val("rst.tc", 16'd0);
    step(2);
    check_next(digits[0]);
    check_next(disp[0]);
    check_next({15'b0, running[0]});
    check_next({15'b0, done[0]});
    check_next({15'b0, tc[0]});
    rst   = 1'b0;
    start = '0;
    expect_val("idle.running", 16'd0);
    step(1);
    check_next({15'b0, running[0]});

    // A: carry and wrap
    start[0] = 1'b1;
    expect_val("a.start.running", 16'd1);
    step(1);
    start[0] = 1'b0;
    check_next({15'b0, running[0]});
    expect_val("a.0999", 16'h0999);
    step(999);
    check_next(digits[0]);
    expect_val("a.1000", 16'h1000);
    expect_val("a.1000.tc", 16'd0);
    step(1);
    check_next(digits[0]);
    check_next({15'b0, tc[0]});
    expect_val("a.9999", 16'h9999);
    expect_val("a.9999.tc", 16'd0);
    step(8999);
    check_next(digits[0]);
    check_next({15'b0, tc[0]});
    expect_val("a.wrap.digits", 16'h0000);
    expect_val("a.wrap.tc", 16'd1);
    expect_val("a.wrap.running", 16'd1);
    step(1);
    check_next(digits[0]);
    check_next({15'b0, tc[0]});
    check_next({15'b0, running[0]});
    expect_val("a.post.digits", 16'h0001);
    expect_val("a.post.tc", 16'd0);
    step(1);
    check_next(digits[0]);
    check_next({15'b0, tc[0]});

    // A: reset mid-count drops a pending start
    rst      = 1'b1;
    start[0] = 1'b1;
    expect_val("a.rstmid.digits", 16'h0000);
    expect_val("a.rstmid.running", 16'd0);
    step(1);
    rst      = 1'b0;
    start[0] = 1'b0;
    check_next(digits[0]);
    check_next({15'b0, running[0]});

    // A: clear beats stop and start
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    expect_val("a.0042", 16'h0042);
    step(42);
    check_next(digits[0]);
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    clear[0] = 1'b1;
    expect_val("a.prio.digits", 16'h0000);
    expect_val("a.prio.running", 16'd0);
    expect_val("a.prio.done", 16'd0);
    step(1);
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    clear[0] = 1'b0;
    check_next(digits[0]);
    check_next({15'b0, running[0]});
    check_next({15'b0, done[0]});

    // B: hold at 9999
    start[1] = 1'b1;
    step(1);
    start[1] = 1'b0;
    expect_val("b.9999", 16'h9999);
    expect_val("b.9999.done", 16'd0);
    step(9999);
    check_next(digits[1]);
    check_next({15'b0, done[1]});
    expect_val("b.hold.digits", 16'h9999);
    expect_val("b.hold.done", 16'd1);
    expect_val("b.hold.tc", 16'd1);
    expect_val("b.hold.running", 16'd0);
    step(1);
    check_next(digits[1]);
    check_next({15'b0, done[1]});
    check_next({15'b0, tc[1]});
    check_next({15'b0, running[1]});
    expect_val("b.hold2.tc", 16'd0);
    expect_val("b.hold2.digits", 16'h9999);
    step(1);
    check_next({15'b0, tc[1]});
    check_next(digits[1]);
    start[1] = 1'b1;
    expect_val("b.start_ign.done", 16'd1);
    expect_val("b.start_ign.running", 16'd0);
    expect_val("b.start_ign.digits", 16'h9999);
    step(1);
    start[1] = 1'b0;
    check_next({15'b0, done[1]});
    check_next({15'b0, running[1]});
    check_next(digits[1]);
    clear[1] = 1'b1;
    expect_val("b.clr.done", 16'd0);
    expect_val("b.clr.digits", 16'h0000);
    step(1);
    clear[1] = 1'b0;
    check_next({15'b0, done[1]});
    check_next(digits[1]);

    // C: pause keeps the partial prescaler period
    start[2] = 1'b1;
    step(1);
    start[2] = 1'b0;
    step(1);
    stop[2] = 1'b1;
    expect_val("c.pause.running", 16'd0);
    step(1);
    stop[2] = 1'b0;
    check_next({15'b0, running[2]});
    for (int i = 0; i < 10; i++) begin
      expect_val("c.paused.digits", 16'h0000);
      step(1);
      check_next(digits[2]);
    end
    start[2] = 1'b1;
    expect_val("c.resume.running", 16'd1);
    step(1);
    start[2] = 1'b0;
    check_next({15'b0, running[2]});
    expect_val("c.resume1", 16'h0000);
    step(1);
    check_next(digits[2]);
    expect_val("c.resume2", 16'h0001);
    step(1);
    check_next(digits[2]);
    expect_val("c.period.pre", 16'h0001);
    step(3);
    check_next(digits[2]);
    expect_val("c.period.tick", 16'h0002);
    step(1);
    check_next(digits[2]);

    // C: stop coincident with tick still counts
    step(3);
    stop[2] = 1'b1;
    expect_val("c.stoptick.digits", 16'h0003);
    expect_val("c.stoptick.running", 16'd0);
    step(1);
    stop[2] = 1'b0;
    check_next(digits[2]);
    check_next({15'b0, running[2]});

    // C: clear coincident with tick wins
    start[2] = 1'b1;
    step(1);
    start[2] = 1'b0;
    step(3);
    clear[2] = 1'b1;
    expect_val("c.clrtick.digits", 16'h0000);
    expect_val("c.clrtick.tc", 16'd0);
    expect_val("c.clrtick.running", 16'd0);
    step(1);
    clear[2] = 1'b0;
    check_next(digits[2]);
    check_next({15'b0, tc[2]});
    check_next({15'b0, running[2]});

    // C: lap freezes the display when built in, otherwise disp tracks digits
    start[2] = 1'b1;
    step(1);
    start[2] = 1'b0;
    expect_val("c.lap.digits", 16'h0005);
    step(20);
    check_next(digits[2]);
    lap[2] = 1'b1;
    expect_val("c.lap1.disp", 16'h0005);
    step(1);
    lap[2] = 1'b0;
    check_next(disp[2]);
    expect_val("c.lapfrz.digits", 16'h0007);
`ifdef QUAD_CTRL_LAP_EN
    expect_val("c.lapfrz.disp", 16'h0005);
`else
    expect_val("c.lapfrz.disp", 16'h0007);
`endif
    step(8);
    check_next(digits[2]);
    check_next(disp[2]);
    lap[2] = 1'b1;
    expect_val("c.lap2.disp", 16'h0007);
    step(1);
    lap[2] = 1'b0;
    check_next(disp[2]);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/quad_count_ctrl.md
# quad_count_ctrl

Run/pause/clear controller for a four-digit decimal counter. It owns a tick prescaler and a command state machine. It generates the cascaded per-digit enables that drive four single-digit BCD counters, and reports terminal count. It sits between the board's button/command logic and the seven-segment display multiplexer. It is the single point that decides when, and which, digits advance.

## Interface
- TICK_DIV, 100000: clock cycles per count tick; legal range 1..2^24.
- WRAP, 1: 1 = wrap from 9999 to 0000; 0 = stop and hold at 9999.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  single-cycle pulse; begins or resumes counting.
- stop  in  1  single-cycle pulse; pauses counting.
- clear  in  1  single-cycle pulse; zeroes the count and returns to IDLE.
- lap  in  1  single-cycle pulse; toggles the display freeze (macro only, otherwise ignored).
- digits  out  16  live count, {d3,d2,d1,d0}, each nibble 0..9.
- disp  out  16  value for the display mux.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- tc  out  1  one-cycle pulse on the tick that takes the count from 9999 to the next value.

## Operation
- States:
  - IDLE: reset state; count is 0000.
  - RUN
  - PAUSE
  - DONE: only reachable with WRAP=0.
- Command priority is clear > stop > start. Same-cycle combinations resolve to the highest-priority command only.
- Transitions:
  - clear in any state -> IDLE; count 0000; prescaler 0.
  - start in IDLE or PAUSE -> RUN.
  - stop in RUN -> PAUSE.
  - start in RUN or DONE is ignored; stop outside RUN is ignored.
  - In RUN, a tick at 9999 with WRAP=0 -> DONE; count holds at 9999.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick = running && (presc == TICK_DIV-1); the prescaler returns to 0 on tick.
  - TICK_DIV=1 gives a tick on every RUN cycle.
  - The prescaler value is held in PAUSE, so resume continues the partial period. It is zeroed by clear and rst.
- Digit enables: en[0] = tick; en[k] = tick && all lower digits == 9.
- Digit behaviour: each digit wraps 9 -> 0 when enabled, so 0999 -> 1000 happens in one tick.
- Terminal count (tick at 9999):
  - tc pulses in the following cycle.
  - WRAP=1: count becomes 0000 and the block stays in RUN.
  - WRAP=0: count stays at 9999 and the state becomes DONE.
- Without the macro, disp = digits.

## Timing
- Reset values: digits 0x0000, disp 0x0000, running 0, done 0, tc 0, prescaler 0, freeze 0.
- Command latency: a command sampled at edge N changes the state and outputs visible after edge N.
- First tick after start: occurs TICK_DIV cycles after running rises, with prescaler starting at 0.
- Count update: the count registered at the tick edge is visible the next cycle; tc is aligned with the wrapped or held count.
- Clear in the same cycle as a tick: clear wins. Count 0000, no tc.
- Stop in the same cycle as a tick: the tick is still applied, then the block enters PAUSE.
- rst mid-count: all state returns to reset values at the next edge; commands pending in that cycle are dropped.

## Configuration
- QUAD_CTRL_LAP_EN defined:
  - An internal freeze flag toggles on a lap pulse while in RUN or PAUSE.
  - On the freeze rising, a 16-bit snapshot register captures digits.
  - disp = freeze ? snapshot : digits.
  - clear and rst drop freeze.
  - lap is ignored in IDLE and DONE.
- QUAD_CTRL_LAP_EN undefined: no snapshot register; lap is unused; disp = digits.

## Structure
- Package quad_ctrl_pkg holds:
  - the state enum: IDLE, RUN, PAUSE, DONE;
  - NUM_DIGITS = 4;
  - BCD_MAX = 4'd9.
- The prescaler width is $clog2(TICK_DIV) in the module, with a minimum of 1 bit.
- Sub-module bcd_digit (clk, rst, clr, en, q[3:0]), instantiated NUM_DIGITS times:
  - synchronous clear;
  - 9 -> 0 wrap.
- The controller owns the FSM, prescaler, enable chain, tc and lap logic.

## Test plan
- Reset: hold rst 2 cycles with start=1 -> digits 0x0000, running 0, done 0, tc 0; state stays IDLE.
- Carry: TICK_DIV=1, WRAP=1; start, run until digits = 0x0999, one more RUN cycle -> digits 0x1000 next cycle, tc 0.
- Wrap: TICK_DIV=1, WRAP=1; count reaches 0x9999, next tick -> digits 0x0000, tc high exactly 1 cycle, running stays 1.
- Hold: WRAP=0 at 0x9999 plus tick -> done 1, digits stay 0x9999, tc 1 cycle; then start -> no change; then clear -> IDLE, digits 0x0000.
- Pause resume: TICK_DIV=4; start, stop after 2 RUN cycles, wait 10 cycles (digits unchanged), start -> first tick after 2 more RUN cycles.
- Priority: start+stop+clear in the same cycle while RUN at 0x0042 -> IDLE, digits 0x0000. With QUAD_CTRL_LAP_EN: lap at 0x0005 -> disp holds 0x0005 while digits advance; second lap -> disp = digits.
